// File: rtl/mem_stage_pkg.sv
// Shared MEM/WB control-bit positions and MEM-stage FSM encodings.
// Imported by the MEM stage, its RAM and its bus interface.
package mem_stage_pkg;

  localparam int MEM_RD = 1;
  localparam int MEM_WR = 0;
  localparam int WB_M2R = 1;
  localparam int WB_RW  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage, bundled as one bus.
// The master side is the upstream pipeline (EX/MEM) and the slave is the MEM stage.
interface mem_stage_if;

  logic [1:0]  MEM;
  logic [1:0]  WB;
  logic [31:0] ALUres;
  logic [31:0] r2;
  logic [4:0]  regres;

  logic        stall;
  logic [1:0]  WBout;
  logic [31:0] ALUresout;
  logic [31:0] memdata;
  logic [4:0]  regresout;
  logic [31:0] wbdata;

  modport master (
    output MEM, WB, ALUres, r2, regres,
    input  stall, WBout, ALUresout, memdata, regresout, wbdata
  );

  modport slave (
    input  MEM, WB, ALUres, r2, regres,
    output stall, WBout, ALUresout, memdata, regresout, wbdata
  );

endinterface

// File: rtl/mem_stage_data_ram.sv
// Data memory: 2**ADDR_W x 32-bit words, synchronous write, asynchronous read.
// The read port shows the pre-write contents during a same-edge write.
module data_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-RAM access with MEM_LAT wait cycles, stalling upstream meanwhile,
// plus the MEM/WB register; a stalled edge inserts a bubble (WBout=0).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc;
  logic              hold;
  logic              ram_we;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic              unused_addr_bits;

  assign acc = bus.MEM[MEM_RD] | bus.MEM[MEM_WR];
  assign idx = bus.ALUres[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.ALUres[31:ADDR_W+2], bus.ALUres[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && (MEM_LAT > 0)) begin
          hold    = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          hold  = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every non-held, non-reset edge is a completion; that is the only point a store commits.
  assign bus.stall = hold & ~rst;
  assign ram_we    = ~hold & ~rst & bus.MEM[MEM_WR];

  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (idx),
    .wdata (bus.r2),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.WBout     <= '0;
      bus.ALUresout <= '0;
      bus.memdata   <= '0;
      bus.regresout <= '0;
    end else if (hold) begin
      bus.WBout <= '0;
    end else begin
      bus.WBout     <= bus.WB;
      bus.ALUresout <= bus.ALUres;
      bus.memdata   <= bus.MEM[MEM_RD] ? rd_word : 32'h0;
      bus.regresout <= bus.regres;
    end
  end

  assign bus.wbdata = bus.WBout[WB_M2R] ? bus.memdata : bus.ALUresout;

endmodule
